// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage: operand forwarding mux with a registered output stage and a saturating forward-hit counter.
module fwd_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 2,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [AW-1:0]         rs_addr,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic [NSRC-1:0]       fwd_we,
    input  logic [NSRC*AW-1:0]    fwd_addr,
    input  logic [NSRC*WIDTH-1:0] fwd_data,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [2:0]            out_src,
    output logic [CNT_W-1:0]      fwd_hits
);
    logic [WIDTH-1:0] sel_data;
    logic [2:0]       sel_src;
    logic             load;
    // Scan from the oldest source down so the youngest match is written last and wins.
    always_comb begin
        sel_data = rf_data;
        sel_src  = '0;
        for (int k = NSRC - 1; k >= 0; k--)
            if (fwd_we[k] && fwd_addr[k*AW +: AW] == rs_addr) begin
                sel_data = fwd_data[k*WIDTH +: WIDTH];
                sel_src  = 3'(k + 1);
            end
        if (rs_addr == '0) begin
            sel_data = '0;
            sel_src  = '0;
        end
    end
    assign load = !stall && !flush;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            out_data  <= sel_data;
            out_src   <= sel_src;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            fwd_hits <= '0;
        else if (load && in_valid && sel_src != '0 && fwd_hits != '1)
            fwd_hits <= fwd_hits + CNT_W'(1);
    end
endmodule

// File: tb/tb_fwd_operand_stage.sv
// tb_fwd_operand_stage: randomized and directed stimulus with a per-cycle scoreboard against a behavioural model.
module tb_fwd_operand_stage;
    localparam int WIDTH = 32;
    localparam int NSRC  = 2;
    localparam int AW    = 5;
    localparam int CNT_W = 3;
    localparam int HMAX  = 7;

    logic                  clk = 0;
    logic                  rst, in_valid, stall, flush, cnt_clr;
    logic [AW-1:0]         rs_addr;
    logic [WIDTH-1:0]      rf_data;
    logic [NSRC-1:0]       fwd_we;
    logic [NSRC*AW-1:0]    fwd_addr;
    logic [NSRC*WIDTH-1:0] fwd_data;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [2:0]            out_src;
    logic [CNT_W-1:0]      fwd_hits;

    fwd_operand_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall(stall),
        .flush(flush), .cnt_clr(cnt_clr), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .fwd_hits(fwd_hits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [2:0]  s;
        logic [2:0]  h;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic        m_valid = 0;
    logic [31:0] m_data = 0;
    logic [2:0]  m_src = 0;
    int          m_hits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand chosen by the forwarding rules: r0 reads zero, else youngest matching writer, else the register file.
    function automatic void pick(output logic [31:0] d, output logic [2:0] s);
        d = rf_data;
        s = 0;
        if (rs_addr == 0) begin
            d = 0;
            return;
        end
        for (int k = 0; k < NSRC; k++)
            if (fwd_we[k] && fwd_addr[k*AW +: AW] == rs_addr) begin
                d = fwd_data[k*WIDTH +: WIDTH];
                s = 3'(k + 1);
                return;
            end
    endfunction

    task automatic step();
        logic [31:0] d;
        logic [2:0]  s;
        pick(d, s);
        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_hits = 0;
        end else begin
            if (cnt_clr) m_hits = 0;
            else if (!stall && !flush && in_valid && s != 0 && m_hits < HMAX) m_hits++;
            if (flush) begin
                m_valid = 0; m_src = 0;
            end else if (!stall) begin
                m_valid = in_valid; m_data = d; m_src = s;
            end
        end
        q.push_back('{v: m_valid, d: m_data, s: m_src, h: 3'(m_hits)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; cnt_clr = 0; rst = 0;
        rs_addr = 0; rf_data = 0; fwd_we = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    task automatic fwd_req(input logic [31:0] v);
        rs_addr = 5'd9; in_valid = 1; fwd_we = 2'b01;
        fwd_addr = {5'd0, 5'd9}; fwd_data = {32'h0, v}; rf_data = 32'h5;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_valid", 32'(out_valid), 32'(e.v));
            chk("sb_data", out_data, e.d);
            chk("sb_src", 32'(out_src), 32'(e.s));
            chk("sb_hits", 32'(fwd_hits), 32'(e.h));
        end
    end

    initial begin
        idle();
        rst = 1; in_valid = 1; rs_addr = 5'd3; rf_data = 32'hDEAD;
        step(); step();
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", out_data, 0);
        chk("reset_hits", 32'(fwd_hits), 0);

        idle();
        in_valid = 1; rs_addr = 5'd5; rf_data = 32'h11; fwd_we = 2'b11;
        fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        step();
        chk("prio_data", out_data, 32'hAA);
        chk("prio_src", 32'(out_src), 1);
        chk("prio_hits", 32'(fwd_hits), 1);

        fwd_we = 2'b10; fwd_addr = {5'd7, 5'd0}; rs_addr = 5'd7; fwd_data = {32'hCC, 32'h0};
        step();
        chk("src1_data", out_data, 32'hCC);
        chk("src1_src", 32'(out_src), 2);

        rs_addr = 5'd0; fwd_we = 2'b01; fwd_addr = 0; fwd_data = {32'h0, 32'hAA}; rf_data = 32'h55;
        step();
        chk("r0_data", out_data, 0);
        chk("r0_src", 32'(out_src), 0);
        chk("r0_hits", 32'(fwd_hits), 2);

        idle();
        in_valid = 1; rs_addr = 5'd3; rf_data = 32'h1234;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rs_addr = 5'($urandom_range(0, 7)); rf_data = $urandom; in_valid = 1'($urandom);
            fwd_we = 2'($urandom); fwd_addr = 10'($urandom); fwd_data = {$urandom, $urandom};
            step();
            chk("stall_data", out_data, 32'h1234);
            chk("stall_valid", 32'(out_valid), 1);
        end
        flush = 1;
        step();
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_data", out_data, 32'h1234);

        idle();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        for (int i = 0; i < 9; i++) begin
            fwd_req(32'(i));
            step();
        end
        chk("sat_hits", 32'(fwd_hits), 7);
        step();
        chk("sat_hold", 32'(fwd_hits), 7);
        cnt_clr = 1;
        step();
        chk("clr_hits", 32'(fwd_hits), 0);
        cnt_clr = 0;

        for (int i = 0; i < 4; i++) begin
            fwd_req(32'h40 + 32'(i));
            step();
        end
        chk("pre_rst_hits", 32'(fwd_hits), 4);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1; stall = 1; flush = 1; cnt_clr = 1;
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_hits", 32'(fwd_hits), 0);
        idle();
        in_valid = 1; rs_addr = 5'd4; rf_data = 32'h77;
        step();
        chk("post_rst_data", out_data, 32'h77);
        chk("post_rst_valid", 32'(out_valid), 1);

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            stall    = ($urandom_range(0, 99) < 25);
            flush    = ($urandom_range(0, 99) < 10);
            cnt_clr  = ($urandom_range(0, 99) < 4);
            in_valid = ($urandom_range(0, 99) < 80);
            rs_addr  = 5'($urandom_range(0, 7));
            rf_data  = $urandom;
            fwd_we   = 2'($urandom);
            fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data = {$urandom, $urandom};
            step();
        end

        idle();
        step();
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_operand_stage.md
FWD_OPERAND_STAGE -- requirements
Module: fwd_operand_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand data width in bits.
REQ-002 The block SHALL have parameter NSRC, default 2, number of forwarding sources; legal range 1..7.
REQ-003 The block SHALL have parameter AW, default 5, register address width.
REQ-004 The block SHALL have parameter CNT_W, default 16, forward-hit counter width.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: an operand request is present this cycle.
REQ-008 Port rs_addr, input, AW: source register address of the request.
REQ-009 Port rf_data, input, WIDTH: register-file read data for rs_addr.
REQ-010 Port fwd_we, input, NSRC: bit k set means source k writes a register.
REQ-011 Port fwd_addr, input, NSRC*AW: packed destination addresses; source k occupies bits [k*AW +: AW].
REQ-012 Port fwd_data, input, NSRC*WIDTH: packed result data; source k occupies bits [k*WIDTH +: WIDTH].
REQ-013 Port stall, input, 1: hold the output register.
REQ-014 Port flush, input, 1: invalidate the output register.
REQ-015 Port cnt_clr, input, 1: clear the hit counter.
REQ-016 Port out_valid, output, 1: out_data holds a valid operand.
REQ-017 Port out_data, output, WIDTH: registered selected operand.
REQ-018 Port out_src, output, 3: registered source code; 0 = register file, k+1 = forwarding source k.
REQ-019 Port fwd_hits, output, CNT_W: saturating count of forwarded operands accepted.

Function
REQ-020 Source k SHALL match when fwd_we[k]=1, fwd_addr slice k equals rs_addr, and rs_addr is not 0.
REQ-021 Among matching sources, the lowest index (youngest pipeline stage) SHALL win; with no match, rf_data and code 0 SHALL be selected.
REQ-022 rs_addr=0 SHALL always select code 0 with data forced to 0, regardless of rf_data or fwd_* inputs.
REQ-023 Selection SHALL be combinational from current inputs; outputs SHALL be registered, giving 1-cycle latency from request to out_*.
REQ-024 Load cycle (stall=0, flush=0): out_valid<=in_valid, out_data<=selected data, out_src<=selected code.
REQ-025 stall=1, flush=0: out_valid, out_data, and out_src SHALL hold their values; the request is not accepted.
REQ-026 flush=1 SHALL set out_valid<=0 and out_src<=0 with out_data held, overriding stall and in_valid.
REQ-027 When in_valid=0 on a load cycle, out_valid SHALL become 0 and out_data/out_src SHALL still be loaded (don't-care for consumers).
REQ-028 fwd_hits SHALL increment by 1 on a load cycle with in_valid=1 and selected code not 0.
REQ-029 fwd_hits SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 cnt_clr=1 SHALL set fwd_hits to 0 next cycle and take priority over a simultaneous increment.
REQ-031 out_src bits above clog2(NSRC+1) SHALL read 0.

Reset
REQ-032 When rst=1 at a rising edge: out_valid=0, out_data=0, out_src=0, fwd_hits=0; rst SHALL override stall, flush, and cnt_clr.
REQ-033 A request presented in the same cycle as rst=1 SHALL be discarded; the first load SHALL occur on the first edge with rst=0.

Verification
REQ-034 Bench: NSRC=2, rs_addr=5, rf_data=0x11, fwd_we=2'b11, both fwd_addr=5, fwd_data={0xBB,0xAA} -> next cycle out_data=0xAA, out_src=1, fwd_hits=1.
REQ-035 Bench: rs_addr=0, fwd_we=2'b01, fwd_addr[0]=0, fwd_data[0]=0xAA, rf_data=0x55 -> out_data=0, out_src=0, fwd_hits unchanged.
REQ-036 Bench: load 0x1234 with in_valid=1, then stall=1 for 3 cycles with changing inputs -> out_data=0x1234 and out_valid=1 throughout; stall=1 together with flush=1 -> out_valid=0 next cycle.
REQ-037 Bench: CNT_W=3, 9 consecutive forwarded requests -> fwd_hits reads 7 and stays 7; cnt_clr with a simultaneous hit -> 0.
REQ-038 Bench: rst=1 mid-stream with out_valid=1 and fwd_hits=4 -> next cycle all outputs 0; first request after reset appears with 1-cycle latency.
REQ-039 Bench: fwd_we=2'b10, fwd_addr[1]=7, rs_addr=7, fwd_data[1]=0xCC -> out_data=0xCC, out_src=2.
